mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Parametrised system bridge between the CPU M-stage memory port and the data memory, N_DEV word-addressed peripherals (timers etc.) and the interrupt-generator port. Decodes each access by address, passes DM traffic through with zero latency, and runs peripheral reads through a registered, stall-based read path with configurable latency. Illegal accesses (unmapped address, non-word peripheral write, conflicting read/write) produce a one-cycle fault pulse and a sticky fault address. It replaces the fixed two-timer bridge and sits between the CPU core and the DM/peripheral instances in the top-level.

## Interface
- N_DEV, 2: number of peripheral slots (1..8).
- DM_LIMIT, 32'h0000_3000: DM region is [0, DM_LIMIT).
- DEV_BASE, 32'h0000_7F00: base of slot 0.
- DEV_SPAN, 32'h10: bytes per slot; slot i = [DEV_BASE+i*DEV_SPAN, DEV_BASE+(i+1)*DEV_SPAN).
- INT_BASE, 32'h0000_7F20: interrupt-generator word [INT_BASE, INT_BASE+4); must not overlap any slot.
- RD_LAT, 1: peripheral read latency in cycles (>=1).

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_m_data_addr  in  32  byte address of M-stage access.
- cpu_m_data_wdata  in  32  store data.
- cpu_m_data_byteen  in  4  store byte enables (0 = no store).
- cpu_m_data_rd  in  1  M-stage instruction is a load.
- cpu_m_inst_addr  in  32  M-stage PC.
- cpu_m_data_rdata  out  32  load data to CPU.
- cpu_stall  out  1  freeze pipeline (held while peripheral read in flight).
- cpu_fault  out  1  one-cycle pulse on illegal access.
- fault_addr  out  32  sticky byte address of most recent fault.
- m_data_addr / m_data_wdata / m_data_byteen / m_inst_addr  out  32/32/4/32  DM port.
- m_data_rdata  in  32  DM read data.
- dev_we  out  N_DEV  per-slot write strobe.
- dev_addr  out  30  shared word address (addr[31:2]).
- dev_wdata  out  32  shared write data.
- dev_rdata  in  32*N_DEV  slot i occupies bits [32i+31:32i].
- m_int_addr  out  32  interrupt-generator address.
- m_int_byteen  out  4  interrupt-generator byte enables.

## Operation
- Decode (combinational on cpu_m_data_addr): DM, SLOT(i), INT, or UNMAPPED; DM checked first, then slots ascending, then INT.
- DM: m_data_* = cpu_* pass-through always; m_data_byteen = cpu byteen only when region DM, else 0; load returns m_data_rdata same cycle, no stall.
- INT: m_int_addr = cpu addr; m_int_byteen = cpu byteen only when region INT, else 0; load from INT returns 0, no stall.
- SLOT write: byteen must be 4'b1111 -> dev_we[i]=1 for that cycle only, no stall. Any other nonzero byteen -> fault, no strobe.
- SLOT read: FSM path below; dev_we all 0.
- Fault when: region UNMAPPED with load or store; partial slot store; cpu_m_data_rd=1 with byteen!=0. On fault: cpu_fault=1 for that cycle, fault_addr <= cpu addr at the edge, no write to any target, rdata=0.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: slot read -> latch slot index and word address, cnt <= RD_LAT-1, go WAIT; cpu_stall=1 this cycle.
  - WAIT: cpu_stall=1; dev_addr driven from latched address; cnt==0 -> rdata_q <= dev_rdata[slot], go RESP; else cnt--.
  - RESP: cpu_stall=0, cpu_m_data_rdata=rdata_q; next edge -> IDLE unconditionally (request consumed, no re-trigger).
- dev_addr = latched address in WAIT, else cpu_m_data_addr[31:2]; dev_wdata = cpu wdata always.

## Timing
- Reset values: state IDLE, cnt 0, rdata_q 0, fault_addr 0; cpu_stall 0, cpu_fault 0, dev_we 0, m_int_byteen 0; DM outputs follow inputs.
- DM/INT/write accesses: zero added latency.
- Slot read: stall asserted for RD_LAT+1 cycles, data returned in the following (RESP) cycle; RD_LAT=1 -> 2 stall cycles, total 3 cycles in M.
- Reset in WAIT/RESP: next edge IDLE, stall drops, rdata_q cleared, no strobe emitted.
- Back-to-back slot reads: second read starts from IDLE the cycle after RESP.
- cnt width = clog2(RD_LAT)+1; no wrap.

## Test plan
- Store 32'hDEAD_BEEF byteen 4'b1111 to 32'h7F04 -> dev_we=2'b01 one cycle, dev_addr=30'h1FC1, no stall, no fault.
- RD_LAT=1, dev_rdata slot1=32'h1234_5678, load from 32'h7F10 -> stall 2 cycles, cycle 3 stall=0 and rdata=32'h1234_5678.
- Load 32'h0000_0100 with m_data_rdata=32'hA5A5_A5A5 -> rdata same cycle, stall=0.
- Store byteen 4'b0011 to 32'h7F00 -> cpu_fault pulse, dev_we=0, fault_addr=32'h7F00; load 32'h7F40 -> fault, fault_addr=32'h7F40.
- Store byteen 4'b1111 to 32'h7F20 -> m_int_byteen=4'b1111, m_data_byteen=0, dev_we=0.
- Reset asserted in WAIT -> next cycle stall=0, state IDLE, rdata_q=0; fresh load completes normally.

Source files
------------

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bridge
// Purpose  : Routes CPU M-stage memory accesses to the data memory, N_DEV
//            word-addressed peripheral slots, or the interrupt-generator
//            port. DM and interrupt traffic passes through with no added
//            latency. Peripheral reads go through a registered, stall-based
//            read path with RD_LAT cycles of latency. Illegal accesses raise
//            a one-cycle fault pulse and update a sticky fault address.
// Ports    : clk, reset (sync, active-high)
//            cpu_m_*   - CPU M-stage request / load data, cpu_stall, cpu_fault
//            fault_addr- byte address of the most recent faulting access
//            m_data_*  - data-memory port (m_inst_addr passes the M-stage PC)
//            dev_*     - shared peripheral bus, per-slot write strobes
//            m_int_*   - interrupt-generator port
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bridge #(
    parameter int          N_DEV    = 2,
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV_SPAN = 32'h0000_0010,
    parameter logic [31:0] INT_BASE = 32'h0000_7F20,
    parameter int          RD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU M-stage port
    input  logic [31:0]           cpu_m_data_addr,
    input  logic [31:0]           cpu_m_data_wdata,
    input  logic [3:0]            cpu_m_data_byteen,
    input  logic                  cpu_m_data_rd,
    input  logic [31:0]           cpu_m_inst_addr,
    output logic [31:0]           cpu_m_data_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_fault,
    output logic [31:0]           fault_addr,
    // Data memory port
    output logic [31:0]           m_data_addr,
    output logic [31:0]           m_data_wdata,
    output logic [3:0]            m_data_byteen,
    output logic [31:0]           m_inst_addr,
    input  logic [31:0]           m_data_rdata,
    // Peripheral slots
    output logic [N_DEV-1:0]      dev_we,
    output logic [29:0]           dev_addr,
    output logic [31:0]           dev_wdata,
    input  logic [32*N_DEV-1:0]   dev_rdata,
    // Interrupt generator
    output logic [31:0]           m_int_addr,
    output logic [3:0]            m_int_byteen
);

    localparam int c_SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int c_CNT_W = $clog2(RD_LAT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RD_LAT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rdata_q;
    logic [31:0]        r_fault_addr;
    logic [c_SEL_W-1:0] r_slot;
    logic [29:0]        r_waddr;

    logic [N_DEV-1:0]   w_slot_hit;
    logic [c_SEL_W-1:0] w_slot_idx;
    logic [31:0]        w_dev_rd [N_DEV];
    logic               w_is_dm;
    logic               w_any_slot;
    logic               w_is_slot;
    logic               w_is_int;
    logic               w_is_unmapped;
    logic               w_has_store;
    logic               w_fault_raw;
    logic               w_slot_rd;
    logic               w_slot_wr;
    logic               w_start;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Slot bounds are computed with one extra bit so a slot ending at the
    // top of the address space does not wrap to zero.
    generate
        for (genvar i = 0; i < N_DEV; i++) begin : g_slot
            localparam logic [32:0] c_LO = {1'b0, DEV_BASE} + 33'(i) * {1'b0, DEV_SPAN};
            localparam logic [32:0] c_HI = c_LO + {1'b0, DEV_SPAN};
            assign w_slot_hit[i] = ({1'b0, cpu_m_data_addr} >= c_LO) &&
                                   ({1'b0, cpu_m_data_addr} <  c_HI);
            assign w_dev_rd[i]   = dev_rdata[32*i +: 32];
        end
    endgenerate

    // Lowest-numbered matching slot wins.
    always_comb begin
        w_slot_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (w_slot_hit[i]) begin
                w_slot_idx = c_SEL_W'(i);
            end
        end
    end

    assign w_is_dm       = (cpu_m_data_addr < DM_LIMIT);
    assign w_any_slot    = |w_slot_hit;
    assign w_is_slot     = !w_is_dm && w_any_slot;
    assign w_is_int      = !w_is_dm && !w_any_slot &&
                           ({1'b0, cpu_m_data_addr} >= {1'b0, INT_BASE}) &&
                           ({1'b0, cpu_m_data_addr} <  ({1'b0, INT_BASE} + 33'd4));
    assign w_is_unmapped = !w_is_dm && !w_any_slot && !w_is_int;

    // ------------------------------------------------------------------
    // Access classification
    // ------------------------------------------------------------------
    assign w_has_store = |cpu_m_data_byteen;

    // A load that also carries byte enables is ambiguous and is rejected
    // in every region; this also keeps it from starting a slot read.
    assign w_fault_raw = (cpu_m_data_rd && w_has_store) ||
                         (w_is_unmapped && (cpu_m_data_rd || w_has_store)) ||
                         (w_is_slot && w_has_store && (cpu_m_data_byteen != 4'b1111));

    assign w_slot_rd = w_is_slot && cpu_m_data_rd && !w_has_store;
    assign w_slot_wr = w_is_slot && !cpu_m_data_rd && (cpu_m_data_byteen == 4'b1111);
    assign w_start   = !reset && (r_state == c_ST_IDLE) && w_slot_rd;

    // ------------------------------------------------------------------
    // Target ports
    // ------------------------------------------------------------------
    assign m_data_addr   = cpu_m_data_addr;
    assign m_data_wdata  = cpu_m_data_wdata;
    assign m_inst_addr   = cpu_m_inst_addr;
    assign m_data_byteen = (w_is_dm && !w_fault_raw) ? cpu_m_data_byteen : 4'b0000;

    assign m_int_addr    = cpu_m_data_addr;
    assign m_int_byteen  = (!reset && w_is_int && !w_fault_raw) ? cpu_m_data_byteen : 4'b0000;

    // The address is held from the latch while waiting so the slot sees a
    // stable address regardless of what the CPU port shows.
    assign dev_addr  = (r_state == c_ST_WAIT) ? r_waddr : cpu_m_data_addr[31:2];
    assign dev_wdata = cpu_m_data_wdata;

    always_comb begin
        dev_we = '0;
        if (!reset && w_slot_wr) begin
            dev_we[w_slot_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // CPU-side responses
    // ------------------------------------------------------------------
    assign cpu_stall  = !reset && (w_start || (r_state == c_ST_WAIT));
    assign cpu_fault  = !reset && w_fault_raw;
    assign fault_addr = r_fault_addr;

    always_comb begin
        cpu_m_data_rdata = 32'h0000_0000;
        if (r_state == c_ST_RESP) begin
            cpu_m_data_rdata = r_rdata_q;
        end else if (!w_fault_raw && w_is_dm) begin
            cpu_m_data_rdata = m_data_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral read FSM and fault address register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_rdata_q    <= 32'h0000_0000;
            r_fault_addr <= 32'h0000_0000;
            r_slot       <= '0;
            r_waddr      <= '0;
        end else begin
            if (w_fault_raw) begin
                r_fault_addr <= cpu_m_data_addr;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_slot_rd) begin
                        r_slot  <= w_slot_idx;
                        r_waddr <= cpu_m_data_addr[31:2];
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata_q <= w_dev_rd[r_slot];
                        r_state   <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                // The held request is consumed here; returning to IDLE
                // unconditionally prevents the same load from re-triggering.
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bridge
// Purpose  : Directed, table-driven bench for mmio_bridge with hand-written
//            sequences for the multi-cycle peripheral read path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_m_data_addr;
    logic [31:0] cpu_m_data_wdata;
    logic [3:0]  cpu_m_data_byteen;
    logic        cpu_m_data_rd;
    logic [31:0] cpu_m_inst_addr;
    logic [31:0] cpu_m_data_rdata;
    logic        cpu_stall;
    logic        cpu_fault;
    logic [31:0] fault_addr;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic [1:0]  dev_we;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [63:0] dev_rdata;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;

    int n_vec;
    int n_err;

    mmio_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_m_data_addr   (cpu_m_data_addr),
        .cpu_m_data_wdata  (cpu_m_data_wdata),
        .cpu_m_data_byteen (cpu_m_data_byteen),
        .cpu_m_data_rd     (cpu_m_data_rd),
        .cpu_m_inst_addr   (cpu_m_inst_addr),
        .cpu_m_data_rdata  (cpu_m_data_rdata),
        .cpu_stall         (cpu_stall),
        .cpu_fault         (cpu_fault),
        .fault_addr        (fault_addr),
        .m_data_addr       (m_data_addr),
        .m_data_wdata      (m_data_wdata),
        .m_data_byteen     (m_data_byteen),
        .m_inst_addr       (m_inst_addr),
        .m_data_rdata      (m_data_rdata),
        .dev_we            (dev_we),
        .dev_addr          (dev_addr),
        .dev_wdata         (dev_wdata),
        .dev_rdata         (dev_rdata),
        .m_int_addr        (m_int_addr),
        .m_int_byteen      (m_int_byteen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic [31:0] mrd;
        logic [31:0] rdata;
        logic        stall;
        logic        fault;
        logic [1:0]  we;
        logic [3:0]  mbe;
        logic [3:0]  ibe;
        logic [31:0] faddr;   // fault_addr after the edge
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic rd, input logic [31:0] mrd);
        cpu_m_data_addr   = a;
        cpu_m_data_wdata  = wd;
        cpu_m_data_byteen = be;
        cpu_m_data_rd     = rd;
        cpu_m_inst_addr   = a ^ 32'h0040_0000;
        m_data_rdata      = mrd;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                                input logic rd, input logic [31:0] mrd, input logic [31:0] rdata,
                                input logic st, input logic flt, input logic [1:0] we,
                                input logic [3:0] mbe, input logic [3:0] ibe, input logic [31:0] fa);
        vec_t v;
        v.addr = a; v.wdata = wd; v.be = be; v.rd = rd; v.mrd = mrd; v.rdata = rdata;
        v.stall = st; v.fault = flt; v.we = we; v.mbe = mbe; v.ibe = ibe; v.faddr = fa;
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        dev_rdata = {32'h1234_5678, 32'h0BAD_0000};

        //           addr          wdata         be       rd    m_rdata       rdata         st    flt   we     mbe      ibe      faddr
        vecs[0]  = mk(32'h0000_7F04, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000, 32'h0);
        vecs[1]  = mk(32'h0000_0100, 32'h0,        4'b0000, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0);
        vecs[2]  = mk(32'h0000_0200, 32'h0000_0011, 4'b0011, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 4'b0011, 4'b0000, 32'h0);
        vecs[3]  = mk(32'h0000_7F20, 32'h0000_0001, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 4'b0000, 4'b1111, 32'h0);
        vecs[4]  = mk(32'h0000_7F20, 32'h0,        4'b0000, 1'b1, 32'h7777_7777, 32'h0,        1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0);
        vecs[5]  = mk(32'h0000_7F00, 32'h0000_FFFF, 4'b0011, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 32'h0000_7F00);
        vecs[6]  = mk(32'h0000_7F40, 32'h0,        4'b0000, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 32'h0000_7F40);
        vecs[7]  = mk(32'h0000_0100, 32'h1111_1111, 4'b1111, 1'b1, 32'h5555_5555, 32'h0,        1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 32'h0000_0100);
        vecs[8]  = mk(32'h0000_7F1C, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b10, 4'b0000, 4'b0000, 32'h0000_0100);
        vecs[9]  = mk(32'h0000_2FFC, 32'h0,        4'b0000, 1'b1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0000_0100);
        vecs[10] = mk(32'h0000_3000, 32'h0,        4'b0000, 1'b1, 32'h0F0F_0F0F, 32'h0,        1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 32'h0000_3000);
        vecs[11] = mk(32'h0000_5000, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 32'h0000_3000);
        vecs[12] = mk(32'h0000_7F24, 32'h0000_0002, 4'b1111, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000, 32'h0000_7F24);

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(32'h0000_7F20, 32'h1, 4'b1111, 1'b0, 32'h0);
        @(negedge clk);
        #2;
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_fault", {31'b0, cpu_fault}, 32'h0);
        check("rst_int_be", {28'b0, m_int_byteen}, 32'h0);
        drive(32'h0000_7F04, 32'h1, 4'b1111, 1'b0, 32'h0);
        #1;
        check("rst_dev_we", {30'b0, dev_we}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_fault_addr", fault_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rd, vecs[i].mrd);
            #2;
            check($sformatf("v%0d_rdata", i), cpu_m_data_rdata, vecs[i].rdata);
            check($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].stall});
            check($sformatf("v%0d_fault", i), {31'b0, cpu_fault}, {31'b0, vecs[i].fault});
            check($sformatf("v%0d_dev_we", i), {30'b0, dev_we}, {30'b0, vecs[i].we});
            check($sformatf("v%0d_m_be", i), {28'b0, m_data_byteen}, {28'b0, vecs[i].mbe});
            check($sformatf("v%0d_int_be", i), {28'b0, m_int_byteen}, {28'b0, vecs[i].ibe});
            check($sformatf("v%0d_dev_addr", i), {2'b0, dev_addr}, {2'b0, vecs[i].addr[31:2]});
            check($sformatf("v%0d_m_addr", i), m_data_addr, vecs[i].addr);
            check($sformatf("v%0d_dev_wdata", i), dev_wdata, vecs[i].wdata);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_fault_addr", i), fault_addr, vecs[i].faddr);
            @(negedge clk);
        end
        check("v0_dev_addr_const", {2'b0, vecs[0].addr[31:2]}, 32'h0000_1FC1);

        // ---------------- slot read, RD_LAT=1 ----------------
        drive(32'h0000_7F10, 32'h0, 4'b0000, 1'b1, 32'h0);
        #2;
        check("rd1_c1_stall", {31'b0, cpu_stall}, 32'h1);
        check("rd1_c1_dev_we", {30'b0, dev_we}, 32'h0);
        @(negedge clk);
        #2;
        check("rd1_c2_stall", {31'b0, cpu_stall}, 32'h1);
        check("rd1_c2_dev_addr", {2'b0, dev_addr}, 32'h0000_1FC4);
        @(negedge clk);
        #2;
        check("rd1_c3_stall", {31'b0, cpu_stall}, 32'h0);
        check("rd1_c3_rdata", cpu_m_data_rdata, 32'h1234_5678);

        // ---------------- back-to-back slot read ----------------
        @(negedge clk);
        drive(32'h0000_7F00, 32'h0, 4'b0000, 1'b1, 32'h0);
        #2;
        check("rd2_c1_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        #2;
        check("rd2_c2_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        #2;
        check("rd2_c3_stall", {31'b0, cpu_stall}, 32'h0);
        check("rd2_c3_rdata", cpu_m_data_rdata, 32'h0BAD_0000);

        // ---------------- reset while waiting ----------------
        @(negedge clk);
        drive(32'h0000_7F14, 32'h0, 4'b0000, 1'b1, 32'h0);
        #2;
        check("rst_wait_c1_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        #2;
        check("rst_wait_c2_stall", {31'b0, cpu_stall}, 32'h1);
        reset = 1'b1;
        drive(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 32'h0);
        #1;
        check("rst_wait_dev_we", {30'b0, dev_we}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_wait_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_wait_state", {30'b0, dut.r_state}, 32'h0);
        check("rst_wait_rdata_q", dut.r_rdata_q, 32'h0);
        @(negedge clk);
        drive(32'h0000_7F10, 32'h0, 4'b0000, 1'b1, 32'h0);
        #2;
        check("rd3_c1_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        #2;
        check("rd3_c2_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        #2;
        check("rd3_c3_stall", {31'b0, cpu_stall}, 32'h0);
        check("rd3_c3_rdata", cpu_m_data_rdata, 32'h1234_5678);
        @(negedge clk);
        drive(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 32'h0);
        #2;
        check("rd3_after_stall", {31'b0, cpu_stall}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
